// File: rtl/dpram_pkg.sv
// Shared defaults and port-select type for the dual-port RAM initiator.
// The round-robin pointer names the port that wins an address conflict.
package dpram_pkg;

  localparam int AW_DEF = 4;
  localparam int DW_DEF = 8;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_sel_e;

  function automatic port_sel_e other_port(input port_sel_e p);
    return (p == PORT_A) ? PORT_B : PORT_A;
  endfunction

endpackage

// File: rtl/dpram_req_slot.sv
// One channel's single-entry pending-request slot.
// Ready is derived from slot state and the issue grant only, never from req_valid_i.
module dpram_req_slot
  import dpram_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req_valid_i,
  input  logic          req_write_i,
  input  logic [AW-1:0] req_addr_i,
  input  logic [DW-1:0] req_wdata_i,
  input  logic          issue_i,
  output logic          req_ready_o,
  output logic          pend_o,
  output logic          write_o,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] wdata_o
);

  logic          pend_q, pend_d;
  logic          write_q, write_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          accept;

  // Slot frees in the same cycle it issues, so a new request can land behind it.
  assign req_ready_o = !pend_q || issue_i;
  assign accept      = req_valid_i && req_ready_o;

  always_comb begin
    pend_d  = pend_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (accept) begin
      pend_d  = 1'b1;
      write_d = req_write_i;
      addr_d  = req_addr_i;
      wdata_d = req_wdata_i;
    end else if (issue_i) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q  <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      pend_q  <= pend_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign pend_o  = pend_q;
  assign write_o = write_q;
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;

endmodule

// File: rtl/dualport_initiator.sv
// Two-channel initiator for a true dual-port RAM: issues each channel's slot,
// serialising same-address accesses involving a write with a round-robin pointer.
module dualport_initiator
  import dpram_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req_valid_a,
  output logic          req_ready_a,
  input  logic          req_write_a,
  input  logic [AW-1:0] req_addr_a,
  input  logic [DW-1:0] req_wdata_a,
  output logic          rsp_valid_a,
  output logic [DW-1:0] rsp_rdata_a,
  output logic [AW-1:0] ram_addr_a,
  output logic          ram_read_a,
  output logic          ram_write_a,
  output logic [DW-1:0] ram_wdata_a,
  input  logic [DW-1:0] ram_rdata_a,
  input  logic          req_valid_b,
  output logic          req_ready_b,
  input  logic          req_write_b,
  input  logic [AW-1:0] req_addr_b,
  input  logic [DW-1:0] req_wdata_b,
  output logic          rsp_valid_b,
  output logic [DW-1:0] rsp_rdata_b,
  output logic [AW-1:0] ram_addr_b,
  output logic          ram_read_b,
  output logic          ram_write_b,
  output logic [DW-1:0] ram_wdata_b,
  input  logic [DW-1:0] ram_rdata_b,
  output logic [7:0]    conflict_cnt
);

  logic          pend_a, pend_b;
  logic          wr_a, wr_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic          issue_a, issue_b;
  logic          conflict;

  port_sel_e     ptr_q, ptr_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          rsp_a_q, rsp_a_d;
  logic          rsp_b_q, rsp_b_d;

  dpram_req_slot #(.AW(AW), .DW(DW)) u_slot_a (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid_i (req_valid_a),
    .req_write_i (req_write_a),
    .req_addr_i  (req_addr_a),
    .req_wdata_i (req_wdata_a),
    .issue_i     (issue_a),
    .req_ready_o (req_ready_a),
    .pend_o      (pend_a),
    .write_o     (wr_a),
    .addr_o      (addr_a),
    .wdata_o     (wdata_a)
  );

  dpram_req_slot #(.AW(AW), .DW(DW)) u_slot_b (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid_i (req_valid_b),
    .req_write_i (req_write_b),
    .req_addr_i  (req_addr_b),
    .req_wdata_i (req_wdata_b),
    .issue_i     (issue_b),
    .req_ready_o (req_ready_b),
    .pend_o      (pend_b),
    .write_o     (wr_b),
    .addr_o      (addr_b),
    .wdata_o     (wdata_b)
  );

  // Read/read to one address is harmless on a dual-port RAM; only writes collide.
  assign conflict = pend_a && pend_b && (addr_a == addr_b) && (wr_a || wr_b);
  assign issue_a  = pend_a && (!conflict || (ptr_q == PORT_A));
  assign issue_b  = pend_b && (!conflict || (ptr_q == PORT_B));

  always_comb begin
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    rsp_a_d = issue_a && !wr_a;
    rsp_b_d = issue_b && !wr_b;
    if (conflict) begin
      ptr_d = other_port(ptr_q);
      if (cnt_q != 8'hFF) begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q   <= PORT_A;
      cnt_q   <= 8'd0;
      rsp_a_q <= 1'b0;
      rsp_b_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      rsp_a_q <= rsp_a_d;
      rsp_b_q <= rsp_b_d;
    end
  end

  assign ram_addr_a   = addr_a;
  assign ram_wdata_a  = wdata_a;
  assign ram_write_a  = issue_a && wr_a;
  assign ram_read_a   = issue_a && !wr_a;
  assign ram_addr_b   = addr_b;
  assign ram_wdata_b  = wdata_b;
  assign ram_write_b  = issue_b && wr_b;
  assign ram_read_b   = issue_b && !wr_b;

  // The RAM registers its read data, so it lines up with the response flag.
  assign rsp_valid_a  = rsp_a_q;
  assign rsp_rdata_a  = ram_rdata_a;
  assign rsp_valid_b  = rsp_b_q;
  assign rsp_rdata_b  = ram_rdata_b;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_dualport_initiator.sv
// Randomised scoreboard bench for dualport_initiator with a behavioural RAM and
// a transaction-level reference of slots, arbitration and expected read data.
module tb_dualport_initiator;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid_a = 1'b0, req_write_a = 1'b0;
  logic [AW-1:0] req_addr_a = '0;
  logic [DW-1:0] req_wdata_a = '0;
  logic          req_valid_b = 1'b0, req_write_b = 1'b0;
  logic [AW-1:0] req_addr_b = '0;
  logic [DW-1:0] req_wdata_b = '0;
  logic          req_ready_a, req_ready_b;
  logic          rsp_valid_a, rsp_valid_b;
  logic [DW-1:0] rsp_rdata_a, rsp_rdata_b;
  logic [AW-1:0] ram_addr_a, ram_addr_b;
  logic          ram_read_a, ram_write_a, ram_read_b, ram_write_b;
  logic [DW-1:0] ram_wdata_a, ram_wdata_b;
  logic [DW-1:0] ram_rdata_a = '0, ram_rdata_b = '0;
  logic [7:0]    conflict_cnt;

  always #5 clk = ~clk;

  dualport_initiator #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid_a(req_valid_a), .req_ready_a(req_ready_a), .req_write_a(req_write_a),
    .req_addr_a(req_addr_a), .req_wdata_a(req_wdata_a),
    .rsp_valid_a(rsp_valid_a), .rsp_rdata_a(rsp_rdata_a),
    .ram_addr_a(ram_addr_a), .ram_read_a(ram_read_a), .ram_write_a(ram_write_a),
    .ram_wdata_a(ram_wdata_a), .ram_rdata_a(ram_rdata_a),
    .req_valid_b(req_valid_b), .req_ready_b(req_ready_b), .req_write_b(req_write_b),
    .req_addr_b(req_addr_b), .req_wdata_b(req_wdata_b),
    .rsp_valid_b(rsp_valid_b), .rsp_rdata_b(rsp_rdata_b),
    .ram_addr_b(ram_addr_b), .ram_read_b(ram_read_b), .ram_write_b(ram_write_b),
    .ram_wdata_b(ram_wdata_b), .ram_rdata_b(ram_rdata_b),
    .conflict_cnt(conflict_cnt)
  );

  // Environment RAM: registered read data, one cycle latency.
  logic [DW-1:0] ram_mem [16];
  always @(posedge clk) begin
    if (ram_write_a) ram_mem[ram_addr_a] <= ram_wdata_a;
    if (ram_write_b) ram_mem[ram_addr_b] <= ram_wdata_b;
    if (ram_read_a)  ram_rdata_a <= ram_mem[ram_addr_a];
    if (ram_read_b)  ram_rdata_b <= ram_mem[ram_addr_b];
  end

  int checks = 0;
  int failures = 0;

  // Reference state: one pending request per channel, winner pointer, counter, memory image.
  bit            m_pend [2];
  bit            m_wr   [2];
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_wd   [2];
  int            m_ptr;
  int            m_cnt;
  logic [DW-1:0] m_mem  [16];
  logic [DW-1:0] exp_a [$];
  logic [DW-1:0] exp_b [$];
  logic [DW-1:0] e_a, e_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic model_issue(output bit conf, output bit ia, output bit ib);
    conf = m_pend[0] && m_pend[1] && (m_addr[0] == m_addr[1]) && (m_wr[0] || m_wr[1]);
    ia = m_pend[0] && (!conf || m_ptr == 0);
    ib = m_pend[1] && (!conf || m_ptr == 1);
  endtask

  task automatic model_reset();
    m_pend[0] = 0; m_pend[1] = 0;
    m_ptr = 0;
    m_cnt = 0;
    exp_a.delete();
    exp_b.delete();
  endtask

  task automatic compare();
    bit conf, ia, ib;
    model_issue(conf, ia, ib);
    chk("ram_read_a",  ram_read_a,  32'(ia && !m_wr[0]));
    chk("ram_write_a", ram_write_a, 32'(ia && m_wr[0]));
    chk("ram_read_b",  ram_read_b,  32'(ib && !m_wr[1]));
    chk("ram_write_b", ram_write_b, 32'(ib && m_wr[1]));
    if (ia) chk("ram_addr_a", ram_addr_a, 32'(m_addr[0]));
    if (ib) chk("ram_addr_b", ram_addr_b, 32'(m_addr[1]));
    if (ia && m_wr[0]) chk("ram_wdata_a", ram_wdata_a, 32'(m_wd[0]));
    if (ib && m_wr[1]) chk("ram_wdata_b", ram_wdata_b, 32'(m_wd[1]));
    chk("req_ready_a", req_ready_a, 32'(!m_pend[0] || ia));
    chk("req_ready_b", req_ready_b, 32'(!m_pend[1] || ib));
    chk("conflict_cnt", conflict_cnt, 32'(m_cnt));
  endtask

  // Drive one cycle of requests at a falling edge, predict the rising edge, then check.
  task automatic step(input bit va, input bit wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                      input bit vb, input bit wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
    bit conf, ia, ib, acc_a, acc_b;
    model_issue(conf, ia, ib);
    acc_a = va && (!m_pend[0] || ia);
    acc_b = vb && (!m_pend[1] || ib);
    req_valid_a = va; req_write_a = wa; req_addr_a = aa; req_wdata_a = da;
    req_valid_b = vb; req_write_b = wb; req_addr_b = ab; req_wdata_b = db;
    if (ia && !m_wr[0]) exp_a.push_back(m_mem[m_addr[0]]);
    if (ib && !m_wr[1]) exp_b.push_back(m_mem[m_addr[1]]);
    if (ia && m_wr[0]) m_mem[m_addr[0]] = m_wd[0];
    if (ib && m_wr[1]) m_mem[m_addr[1]] = m_wd[1];
    if (acc_a) begin m_pend[0] = 1; m_wr[0] = wa; m_addr[0] = aa; m_wd[0] = da; end
    else if (ia) m_pend[0] = 0;
    if (acc_b) begin m_pend[1] = 1; m_wr[1] = wb; m_addr[1] = ab; m_wd[1] = db; end
    else if (ib) m_pend[1] = 0;
    if (conf) begin
      m_ptr = 1 - m_ptr;
      if (m_cnt < 255) m_cnt++;
    end
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic idle();
    step(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  // Response monitor: every rsp_valid must match the oldest outstanding read of that channel.
  always @(negedge clk) begin
    if (rsp_valid_a === 1'b1) begin
      if (exp_a.size() == 0) begin
        checks++; failures++;
        $display("FAIL rsp_a_unexpected actual=0x%0h required=none t=%0t", rsp_rdata_a, $time);
      end else begin
        e_a = exp_a.pop_front();
        chk("rsp_rdata_a", 32'(rsp_rdata_a), 32'(e_a));
      end
    end
    if (rsp_valid_b === 1'b1) begin
      if (exp_b.size() == 0) begin
        checks++; failures++;
        $display("FAIL rsp_b_unexpected actual=0x%0h required=none t=%0t", rsp_rdata_b, $time);
      end else begin
        e_b = exp_b.pop_front();
        chk("rsp_rdata_b", 32'(rsp_rdata_b), 32'(e_b));
      end
    end
  end

  initial begin
    logic [AW-1:0] ra, rb;
    for (int i = 0; i < 16; i++) begin
      ram_mem[i] = '0;
      m_mem[i] = '0;
    end
    model_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ram_read_a", ram_read_a, 0);
    chk("rst_ram_write_b", ram_write_b, 0);
    chk("rst_rsp_valid_a", rsp_valid_a, 0);
    chk("rst_cnt", conflict_cnt, 0);
    reset_n = 1'b1;
    #1;
    compare();
    chk("first_ready_a", req_ready_a, 1);
    chk("first_ready_b", req_ready_b, 1);

    // Different addresses: both writes issue together.
    step(1, 1, 4'd1, 8'hCA, 1, 1, 4'd2, 8'h35);
    chk("d31_wr_a", ram_write_a, 1);
    chk("d31_wr_b", ram_write_b, 1);
    idle();
    chk("d31_cnt", conflict_cnt, 0);

    // Write/write conflict, pointer starts at A.
    step(1, 1, 4'd4, 8'hBC, 1, 1, 4'd4, 8'h43);
    chk("d32_wr_a_first", ram_write_a, 1);
    chk("d32_wr_b_held", ram_write_b, 0);
    idle();
    chk("d32_wr_b_next", ram_write_b, 1);
    chk("d32_wr_a_done", ram_write_a, 0);
    chk("d32_cnt", conflict_cnt, 1);
    step(1, 0, 4'd4, 8'h00, 0, 0, '0, '0);
    idle();
    chk("d32_rsp_valid", rsp_valid_a, 1);
    chk("d32_readback", rsp_rdata_a, 8'h43);

    // Pointer now favours B.
    step(1, 1, 4'd4, 8'h69, 1, 1, 4'd4, 8'h96);
    chk("d33_wr_b_first", ram_write_b, 1);
    chk("d33_wr_a_held", ram_write_a, 0);
    idle();
    chk("d33_wr_a_next", ram_write_a, 1);
    chk("d33_cnt", conflict_cnt, 2);
    step(1, 0, 4'd4, 8'h00, 0, 0, '0, '0);
    idle();
    chk("d33_readback", rsp_rdata_a, 8'h69);

    // Read/read at one address is not a conflict.
    step(1, 1, 4'd3, 8'h5A, 0, 0, '0, '0);
    idle();
    step(1, 0, 4'd3, 8'h00, 1, 0, 4'd3, 8'h00);
    chk("d34_rd_a", ram_read_a, 1);
    chk("d34_rd_b", ram_read_b, 1);
    idle();
    chk("d34_rsp_a", rsp_valid_a, 1);
    chk("d34_rsp_b", rsp_valid_b, 1);
    chk("d34_data_a", rsp_rdata_a, 8'h5A);
    chk("d34_data_b", rsp_rdata_b, 8'h5A);
    chk("d34_cnt", conflict_cnt, 2);

    // Write A / read B same address, pointer back at A.
    step(1, 1, 4'd5, 8'hD3, 1, 0, 4'd5, 8'h00);
    chk("d35_wr_a", ram_write_a, 1);
    chk("d35_rd_b_held", ram_read_b, 0);
    idle();
    chk("d35_rd_b", ram_read_b, 1);
    chk("d35_no_early_rsp", rsp_valid_b, 0);
    idle();
    chk("d35_rsp_b", rsp_valid_b, 1);
    chk("d35_data_b", rsp_rdata_b, 8'hD3);
    chk("d35_cnt", conflict_cnt, 3);

    // Random traffic biased onto two addresses to provoke conflicts and saturation.
    for (int n = 0; n < 3000; n++) begin
      ra = ($urandom_range(0, 9) < 7) ? AW'($urandom_range(0, 1)) : AW'($urandom_range(0, 15));
      rb = ($urandom_range(0, 9) < 7) ? AW'($urandom_range(0, 1)) : AW'($urandom_range(0, 15));
      step($urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)), ra, DW'($urandom_range(0, 255)),
           $urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)), rb, DW'($urandom_range(0, 255)));
    end
    chk("cnt_saturated", conflict_cnt, 255);
    repeat (3) idle();
    chk("drain_a", exp_a.size(), 0);
    chk("drain_b", exp_b.size(), 0);

    // Streaming reads on A, then reset in the middle.
    for (int i = 0; i < 6; i++) step(1, 0, AW'(i), '0, 0, 0, '0, '0);
    chk("pre_rst_rd_a", ram_read_a, 1);
    chk("pre_rst_rsp_a", rsp_valid_a, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rd_a", ram_read_a, 0);
    chk("async_rsp_a", rsp_valid_a, 0);
    model_reset();
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
    repeat (2) @(negedge clk);
    chk("in_rst_rd_a", ram_read_a, 0);
    reset_n = 1'b1;
    #1;
    compare();
    repeat (4) idle();
    chk("post_rst_q_a", exp_a.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
